// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the pooling and conv processing elements.
package pe_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DRAIN,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic int win_count(input int in_dim);
        return (in_dim / 2) * (in_dim / 2);
    endfunction

    // Counter width that stays legal when only one index value exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_2x2_unit_if.sv
// Read port to the conv result buffer and write port to the pool buffer.
interface maxpool_2x2_unit_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int OADDR_W = 2
) ();

    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [DATA_W-1:0]  rd_data;
    logic                      wr_en;
    logic [OADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0]  wr_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/maxpool_2x2_unit_smax_cmp.sv
// Combinational signed two-input max; ties keep the current operand b.
module smax_cmp #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/maxpool_2x2_unit.sv
// Stride-2 2x2 max pooling over a square signed map held in the conv buffer.
module maxpool_2x2_unit
    import pe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IN_DIM  = 4,
    parameter int ADDR_W  = 4,
    parameter int OADDR_W = 2
) (
    input  logic clk,
    input  logic rst,
    maxpool_2x2_unit_if.master bus,
    output logic busy,
    output logic done
);

    localparam int HALF = IN_DIM / 2;
    localparam int CW   = idx_w(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    state_t state_q, state_d;

    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [1:0]    k_q, k_d;

    logic signed [DATA_W-1:0] max_q, max_d, max_cmp;

    logic                     rd_en_c;
    logic [ADDR_W-1:0]        rd_addr_c;
    logic                     wr_en_c;
    logic [OADDR_W-1:0]       wr_addr_c;
    logic signed [DATA_W-1:0] wr_data_c;
    logic                     busy_c;
    logic                     done_c;

    smax_cmp #(
        .DATA_W(DATA_W)
    ) u_cmp (
        .a(bus.rd_data),
        .b(max_q),
        .y(max_cmp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            max_q   <= max_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        max_d   = max_q;
        unique case (state_q)
            ST_IDLE: begin
                k_d     = '0;
                state_d = ST_RD;
            end
            ST_RD: begin
                // rd_data carries the reply to the previous cycle's read.
                if (k_q == 2'd1) begin
                    max_d = bus.rd_data;
                end else if (k_q != 2'd0) begin
                    max_d = max_cmp;
                end
                if (k_q == 2'd3) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                max_d   = max_cmp;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        i_d     = i_q + CW'(1);
                        state_d = ST_RD;
                    end
                end else begin
                    j_d     = j_q + CW'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        unique case (1'b1)
            (state_q == ST_RD): begin
                rd_en_c   = 1'b1;
                busy_c    = 1'b1;
                // Row 2i+k[1], column 2j+k[0], row-major.
                rd_addr_c = ADDR_W'(int'({i_q, k_q[1]}) * IN_DIM
                                    + int'({j_q, k_q[0]}));
            end
            (state_q == ST_DRAIN): begin
                busy_c = 1'b1;
            end
            (state_q == ST_WR): begin
                wr_en_c   = 1'b1;
                busy_c    = 1'b1;
                wr_addr_c = OADDR_W'(int'(i_q) * HALF + int'(j_q));
                wr_data_c = max_q;
            end
            (state_q == ST_DONE): begin
                done_c = 1'b1;
            end
            default: begin
                done_c = 1'b0;
            end
        endcase
    end

    assign bus.rd_en   = rd_en_c;
    assign bus.rd_addr = rd_addr_c;
    assign bus.wr_en   = wr_en_c;
    assign bus.wr_addr = wr_addr_c;
    assign bus.wr_data = wr_data_c;
    assign busy        = busy_c;
    assign done        = done_c;

endmodule

// File: tb/tb_maxpool_2x2_unit.sv
// Scoreboard bench for maxpool_2x2_unit at IN_DIM=4 and IN_DIM=2.
module tb_maxpool_2x2_unit;

    typedef struct {
        int a;
        int d;
        int c;
    } wexp_t;

    logic clk;
    logic rst0;
    logic rst1;
    logic busy0, done0;
    logic busy1, done1;

    int n_vec;
    int n_err;
    int cyc0;
    int cyc1;

    int mem0 [16];
    int mem1 [4];

    int    rq0 [$];
    int    rq1 [$];
    wexp_t wq0 [$];
    wexp_t wq1 [$];

    logic [3:0] seen0;
    logic [3:0] seen1;

    maxpool_2x2_unit_if #(.DATA_W(16), .ADDR_W(4), .OADDR_W(2)) b0 ();
    maxpool_2x2_unit_if #(.DATA_W(16), .ADDR_W(2), .OADDR_W(1)) b1 ();

    maxpool_2x2_unit #(
        .DATA_W(16), .IN_DIM(4), .ADDR_W(4), .OADDR_W(2)
    ) u0 (
        .clk(clk), .rst(rst0), .bus(b0), .busy(busy0), .done(done0)
    );

    maxpool_2x2_unit #(
        .DATA_W(16), .IN_DIM(2), .ADDR_W(2), .OADDR_W(1)
    ) u1 (
        .clk(clk), .rst(rst1), .bus(b1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer models: read data returns one cycle after the strobe.
    always @(posedge clk) begin
        if (b0.rd_en) b0.rd_data <= 16'(mem0[b0.rd_addr]);
        if (b1.rd_en) b1.rd_data <= 16'(mem1[b1.rd_addr]);
    end

    // Cycle index as the DUT sees it: 0 is the IDLE cycle after reset.
    always @(posedge clk) begin
        if (rst0) cyc0 = 0; else cyc0++;
        if (rst1) cyc1 = 0; else cyc1++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_run(input int d, input int dim);
        int h, i, j, a, v, m;
        wexp_t e;
        h = dim / 2;
        for (int w = 0; w < h * h; w++) begin
            i = w / h;
            j = w % h;
            m = 0;
            for (int k = 0; k < 4; k++) begin
                a = (2 * i + k / 2) * dim + 2 * j + k % 2;
                v = (d == 0) ? mem0[a] : mem1[a];
                if (k == 0 || v > m) m = v;
                if (d == 0) rq0.push_back(a); else rq1.push_back(a);
            end
            e.a = w;
            e.d = m;
            e.c = 6 + 6 * w;
            if (d == 0) wq0.push_back(e); else wq1.push_back(e);
        end
    endtask

    task automatic mon(input int d, input int cyc, input int lat,
                       input logic re, input int ra,
                       input logic we, input int wa, input int wd,
                       input logic bz, input logic dn);
        bit    act;
        int    ph;
        int    ea;
        wexp_t e;
        bit    emp;
        bit    was;
        act = (cyc >= 1) && (cyc < lat);
        ph  = (cyc >= 1) ? (cyc - 1) % 6 : 0;
        chk($sformatf("d%0d c%0d rd_en", d, cyc), int'(re), int'(act && ph < 4));
        chk($sformatf("d%0d c%0d wr_en", d, cyc), int'(we), int'(act && ph == 5));
        chk($sformatf("d%0d c%0d busy", d, cyc), int'(bz), int'(act));
        chk($sformatf("d%0d c%0d done", d, cyc), int'(dn), int'(cyc >= lat));
        chk($sformatf("d%0d c%0d rd_wr_excl", d, cyc), int'(re && we), 0);
        if (cyc == 0) begin
            chk($sformatf("d%0d rst rd_addr", d), ra, 0);
            chk($sformatf("d%0d rst wr_addr", d), wa, 0);
            chk($sformatf("d%0d rst wr_data", d), wd, 0);
            if (d == 0) seen0 = '0; else seen1 = '0;
        end
        if (re) begin
            emp = (d == 0) ? (rq0.size() == 0) : (rq1.size() == 0);
            chk($sformatf("d%0d c%0d rd_unexpected", d, cyc), int'(emp), 0);
            if (!emp) begin
                ea = (d == 0) ? rq0.pop_front() : rq1.pop_front();
                chk($sformatf("d%0d c%0d rd_addr", d, cyc), ra, ea);
            end
        end
        if (we) begin
            emp = (d == 0) ? (wq0.size() == 0) : (wq1.size() == 0);
            chk($sformatf("d%0d c%0d wr_unexpected", d, cyc), int'(emp), 0);
            if (!emp) begin
                e = (d == 0) ? wq0.pop_front() : wq1.pop_front();
                chk($sformatf("d%0d c%0d wr_addr", d, cyc), wa, e.a);
                chk($sformatf("d%0d c%0d wr_data", d, cyc), wd, e.d);
                chk($sformatf("d%0d c%0d wr_cycle", d, cyc), cyc, e.c);
            end
            was = (d == 0) ? seen0[wa[1:0]] : seen1[wa[1:0]];
            chk($sformatf("d%0d c%0d wr_once a%0d", d, cyc, wa), int'(was), 0);
            if (d == 0) seen0[wa[1:0]] = 1'b1; else seen1[wa[1:0]] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, cyc0, 25, b0.rd_en, int'(b0.rd_addr), b0.wr_en,
            int'(b0.wr_addr), int'(b0.wr_data), busy0, done0);
        mon(1, cyc1, 7, b1.rd_en, int'(b1.rd_addr), b1.wr_en,
            int'(b1.wr_addr), int'(b1.wr_data), busy1, done1);
    end

    task automatic start(input int d);
        if (d == 0) begin
            rq0.delete();
            wq0.delete();
            push_run(0, 4);
            rst0 = 1'b0;
        end else begin
            rq1.delete();
            wq1.delete();
            push_run(1, 2);
            rst1 = 1'b0;
        end
    endtask

    task automatic finish_run(input int d, input int lat);
        repeat (lat + 20) begin
            @(posedge clk);
            #1;
        end
        if (d == 0) begin
            chk("d0 reads_left", rq0.size(), 0);
            chk("d0 writes_left", wq0.size(), 0);
            rst0 = 1'b1;
        end else begin
            chk("d1 reads_left", rq1.size(), 0);
            chk("d1 writes_left", wq1.size(), 0);
            rst1 = 1'b1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run0();
        start(0);
        finish_run(0, 25);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc0  = 0;
        cyc1  = 0;
        seen0 = '0;
        seen1 = '0;
        rst0  = 1'b1;
        rst1  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 16; n++) mem0[n] = n + 1;
        run0();

        for (int n = 0; n < 16; n++) mem0[n] = -int'($urandom_range(1, 3000));
        mem0[0] = -5;
        mem0[1] = -3;
        mem0[4] = -9;
        mem0[5] = -3;
        run0();

        for (int n = 0; n < 16; n++) mem0[n] = -32768;
        run0();

        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 16; n++) begin
                if (r < 3) mem0[n] = int'($signed(16'($urandom)));
                else mem0[n] = int'($urandom_range(0, 6)) - 3;
            end
            run0();
        end

        for (int n = 0; n < 16; n++) mem0[n] = int'($signed(16'($urandom)));
        start(0);
        for (int g = 0; g < 100 && cyc0 != 14; g++) begin
            @(posedge clk);
            #1;
        end
        chk("d0 reach_cycle_14", cyc0, 14);
        rst0 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        run0();

        mem1[0] = 7;
        mem1[1] = -1;
        mem1[2] = 3;
        mem1[3] = 2;
        start(1);
        finish_run(1, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
